// File: rtl/ram_arbiter_pkg.sv
// Shared types and the two-requester pick function used by the BRAM write/read arbiters.
package ram_arbiter_pkg;

    localparam int NUM_MASTERS = 2;

    typedef logic [NUM_MASTERS-1:0] master_vec_t;

    // One-hot grant: a lone requester always wins, a tie goes to the master named by ptr.
    function automatic master_vec_t rr_pick(input master_vec_t req, input logic ptr);
        master_vec_t gnt;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter with a registered round-robin pointer and a combinational one-hot grant.
module rr_arb2
    import ram_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  master_vec_t i_req,
    input  logic        i_en_update,
    output master_vec_t o_gnt
);

    logic        r_ptr;
    logic        w_ptr_eff;
    master_vec_t w_gnt;

    // Fixed priority is just round-robin with the pointer pinned at master 0.
    assign w_ptr_eff = RR_EN ? r_ptr : 1'b0;
    assign w_gnt     = rr_pick(i_req, w_ptr_eff);
    assign o_gnt     = w_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_en_update && (|w_gnt)) begin
            r_ptr <= w_gnt[0];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one simple-dual-port BRAM between two req/gnt masters, with independent write and read arbitration.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_LEN      = 8,
    parameter int DATA_LEN      = 32,
    parameter bit RR_EN         = 1'b1,
    parameter bit COLLIDE_STALL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] m_wreq,
    output logic [NUM_MASTERS-1:0] m_wgnt,
    input  logic [ADDR_LEN-1:0]    m0_waddr,
    input  logic [ADDR_LEN-1:0]    m1_waddr,
    input  logic [DATA_LEN-1:0]    m0_wdata,
    input  logic [DATA_LEN-1:0]    m1_wdata,
    input  logic [NUM_MASTERS-1:0] m_rreq,
    output logic [NUM_MASTERS-1:0] m_rgnt,
    input  logic [ADDR_LEN-1:0]    m0_raddr,
    input  logic [ADDR_LEN-1:0]    m1_raddr,
    output logic [DATA_LEN-1:0]    m_rdata,
    output logic [NUM_MASTERS-1:0] m_rvalid,
    output logic                   ram_wr_req,
    output logic [ADDR_LEN-1:0]    ram_wr_addr,
    output logic [DATA_LEN-1:0]    ram_wr_data,
    output logic [ADDR_LEN-1:0]    ram_rd_addr,
    input  logic [DATA_LEN-1:0]    ram_rd_data
);

    master_vec_t         w_wreq;
    master_vec_t         w_rreq;
    master_vec_t         w_wpick;
    master_vec_t         w_rpick;
    logic [ADDR_LEN-1:0] w_raddr;
    logic                w_collide;
    logic [ADDR_LEN-1:0] r_raddr;
    master_vec_t         r_rsel;

    // Masking requests during reset keeps every grant, and hence every pointer update, quiet.
    assign w_wreq = rst ? '0 : m_wreq;
    assign w_rreq = rst ? '0 : m_rreq;

    rr_arb2 #(.RR_EN(RR_EN)) u_warb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (w_wreq),
        .i_en_update (1'b1),
        .o_gnt       (w_wpick)
    );

    rr_arb2 #(.RR_EN(RR_EN)) u_rarb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (w_rreq),
        .i_en_update (~w_collide),
        .o_gnt       (w_rpick)
    );

    assign m_wgnt      = w_wpick;
    assign ram_wr_req  = |w_wpick;
    assign ram_wr_addr = w_wpick[1] ? m1_waddr : m0_waddr;
    assign ram_wr_data = w_wpick[1] ? m1_wdata : m0_wdata;

    // A stalled read keeps its pointer, so it is re-granted next cycle and sees the new data.
    assign w_raddr   = w_rpick[1] ? m1_raddr : m0_raddr;
    assign w_collide = COLLIDE_STALL && ram_wr_req && (|w_rpick) && (w_raddr == ram_wr_addr);
    assign m_rgnt    = w_collide ? '0 : w_rpick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr <= '0;
            r_rsel  <= '0;
        end else begin
            r_rsel <= m_rgnt;
            if (|m_rgnt) begin
                r_raddr <= w_raddr;
            end
        end
    end

    assign ram_rd_addr = rst ? '0 : ((|m_rgnt) ? w_raddr : r_raddr);
    assign m_rvalid    = rst ? '0 : r_rsel;
    assign m_rdata     = ram_rd_data;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one simple-dual-port BRAM (1 write port, 1 read port, 1-cycle registered read) between two bus masters.
- Masters use the debug_uart-style req/gnt handshake: master 0 is typically debug_uart, master 1 a local datapath master.
- Write and read ports are arbitrated independently, each with its own round-robin pointer.
- Optional read-after-write collision stall; the read return cycle is steered to the granted master.

Parameters:
- ADDR_LEN, 8, RAM address width in bits.
- DATA_LEN, 32, RAM data width in bits.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with master 0 winning.
- COLLIDE_STALL, 1, 1 = withhold a read grant whose address equals the write granted in the same cycle.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- m_wreq  in  2  per-master write request; bit i belongs to master i.
- m_wgnt  out  2  per-master write grant.
- m0_waddr, m1_waddr  in  ADDR_LEN  write address.
- m0_wdata, m1_wdata  in  DATA_LEN  write data.
- m_rreq  in  2  per-master read request.
- m_rgnt  out  2  per-master read grant.
- m0_raddr, m1_raddr  in  ADDR_LEN  read address.
- m_rdata  out  DATA_LEN  shared read data, copied from ram_rd_data.
- m_rvalid  out  2  one-cycle pulse marking the cycle in which m_rdata is valid for master i.
- ram_wr_req  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_LEN  RAM write address.
- ram_wr_data  out  DATA_LEN  RAM write data.
- ram_rd_addr  out  ADDR_LEN  RAM read address.
- ram_rd_data  in  DATA_LEN  RAM read data, valid one cycle after the address is presented.

Behaviour:
- Handshake
  - A master asserts req with stable addr/data until it sees gnt=1; the transfer happens in the gnt cycle.
  - Grants are combinational from the current req and the registered pointers: zero-latency grant when uncontested, matching "gnt = req".
  - At most one bit of m_wgnt and one bit of m_rgnt is high per cycle.
  - Never grant a master that is not requesting.
- Write arbitration
  - One requester: grant it.
  - Both requesting, RR_EN=1: grant the master selected by wptr. wptr resets to 0. After each write grant, wptr <= the index of the other master.
  - Both requesting, RR_EN=0: always grant master 0.
  - ram_wr_req = |m_wgnt. ram_wr_addr/wr_data are muxed from the granted master; when there is no grant they default to master 0's values.
- Read arbitration
  - Same rules as write, using its own pointer rptr (reset 0).
  - ram_rd_addr is muxed from the granted master; with no grant it holds its last granted value (registered shadow, reset 0).
- Collision (COLLIDE_STALL=1)
  - If the read winner's raddr equals the granted waddr in the same cycle, m_rgnt=0 that cycle and rptr is unchanged.
  - The read is granted the next cycle, so it returns the new data.
  - With COLLIDE_STALL=0 there is no check; the result is the RAM's read-during-write behaviour.
- Read return
  - rsel_q <= m_rgnt every cycle; m_rvalid = rsel_q.
  - m_rdata = ram_rd_data, so the data is valid exactly one cycle after rgnt (the READ_IMM=0 convention).
  - Back-to-back grants to alternating masters produce back-to-back rvalid pulses on the matching bits.
- Reset
  - Outputs while rst=1: m_wgnt=0, m_rgnt=0, m_rvalid=0, ram_wr_req=0, ram_rd_addr=0.
  - Registers cleared: wptr=0, rptr=0, rsel_q=0.
  - A read granted in the cycle before rst is asserted produces no m_rvalid pulse.
- Simultaneous events
  - A write and a read from the same or different masters in one cycle are both granted, subject to the collision rule.
  - A master may hold wreq and rreq together.

Decomposition:
- Package ram_arbiter_pkg holds:
  - NUM_MASTERS=2 constant.
  - typedef for the 2-bit master vector.
  - function rr_pick(req, ptr), returning a one-hot grant.
- One sub-module, rr_arb2: two-requester arbiter with req, ptr register, en_update input and one-hot gnt output.
  - Instantiated twice (write, read). The read instance's update is gated by the collision stall.

Test Plan:
- Single master 0 write: addr 0x10, data 0xDEADBEEF, no contention -> m_wgnt=01 in the same cycle; ram_wr_req=1, ram_wr_addr=0x10, ram_wr_data=0xDEADBEEF.
- Both masters hold wreq (addr 0x01 / 0x02) for 4 cycles, RR_EN=1, each master drops its req once granted then re-asserts -> grants alternate 01,10,01,10. With RR_EN=0 -> master 0 is granted every cycle.
- Read return: master 1 reads 0x20 (preloaded 0x12345678) -> m_rgnt=10 in cycle N; m_rvalid=10 and m_rdata=0x12345678 in cycle N+1; m_rvalid=00 otherwise.
- Collision: master 0 writes 0x05=0xAAAA5555 while master 1 reads 0x05 in the same cycle, COLLIDE_STALL=1 -> cycle N: m_wgnt=01, m_rgnt=00. Cycle N+1: m_rgnt=10. Cycle N+2: m_rdata=0xAAAA5555, m_rvalid=10.
- Concurrent read and write to different addresses: master 0 writes 0x03, master 1 reads 0x04 -> both granted the same cycle; rvalid=10 on the next cycle.
- Reset mid-operation: assert rst in the cycle after a master 0 read grant -> no m_rvalid pulse. After release, both pointers are 0 and a contended request grants master 0 first.
